// File: rtl/toggle_pkg.sv
// Shared op codes and FSM state encoding for the toggle-cell sequencer.
package toggle_pkg;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_UP     = 2'b01;
    localparam logic [1:0] OP_DOWN   = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/t_cell.sv
// Single T flip-flop with synchronous active-high reset to zero.
module t_cell (
    input  logic clk,
    input  logic rst,
    input  logic T,
    output logic q,
    output logic q_bar
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ T;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Command sequencer driving a bank of T cells: load, count up/down, or toggle a mask
// for a programmed number of cycles.
module toggle_seq_ctrl
    import toggle_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [WIDTH-1:0] t_vec,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             busy,
    output logic             done
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [1:0]        r_op;
    logic [WIDTH-1:0]  r_data;
    logic [LEN_W-1:0]  r_cnt;
    logic              w_accept;
    logic [WIDTH-1:0]  w_up_vec;
    logic [WIDTH-1:0]  w_dn_vec;

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign done      = (r_state == ST_DONE);
    assign w_accept  = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_LOAD;
            r_data  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_data <= cmd_data;
                // LOAD always takes exactly one RUN cycle regardless of cmd_len
                r_cnt  <= (cmd_op == OP_LOAD) ? LEN_W'(1) : cmd_len;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt - LEN_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if ((cmd_op != OP_LOAD) && (cmd_len == '0)) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (r_cnt == LEN_W'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Ripple carry/borrow chains: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        logic up_c;
        logic dn_c;
        up_c = 1'b1;
        dn_c = 1'b1;
        w_up_vec = '0;
        w_dn_vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_up_vec[i] = up_c;
            w_dn_vec[i] = dn_c;
            up_c = up_c & q[i];
            dn_c = dn_c & ~q[i];
        end
    end

    always_comb begin
        t_vec = '0;
        if (r_state == ST_RUN) begin
            unique case (r_op)
                OP_LOAD:   t_vec = q ^ r_data;
                OP_UP:     t_vec = w_up_vec;
                OP_DOWN:   t_vec = w_dn_vec;
                OP_TOGGLE: t_vec = r_data;
                default:   t_vec = '0;
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        t_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .T     (t_vec[g]),
            .q     (q[g]),
            .q_bar (q_bar[g])
        );
    end

endmodule
